// File: rtl/tmds_decoder.sv
// TMDS receive decoder: bit-slip alignment on control tokens, then 10b->8b data / 2b control decode.
// Latency: 1 clk from the symbol appearing in the 20-bit window to ve/data/control outputs.
// Backpressure: none; one word accepted every clock, no ready signal.
module tmds_decoder #(
    parameter int LOCK_COUNT = 16,
    parameter int MISS_LIMIT = 2048
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    output logic       locked_out,
    output logic [3:0] slip_offset_out,
    output logic       ve_out,
    output logic [7:0] data_out,
    output logic [1:0] control_out
);

    localparam int TW = $clog2(MISS_LIMIT);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(MISS_LIMIT - 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(LOCK_COUNT);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state, state_nxt;
    logic [9:0]    prev;
    logic [3:0]    offset, offset_nxt;
    logic [CW-1:0] count, count_nxt, count_inc;
    logic [TW-1:0] timer, timer_nxt;
    logic [19:0]   win;
    logic [9:0]    q;
    logic [7:0]    qb, d;
    logic          is_tok;
    logic [1:0]    tok_val;
    logic          ve_nxt;
    logic [7:0]    data_nxt;
    logic [1:0]    control_nxt;

    assign win = {tmds_in, prev};

    // offsets above 9 never occur; the default arm just keeps every window bit in use
    always_comb begin
        q = win[9:0];
        case (offset)
            4'd0: q = win[9:0];
            4'd1: q = win[10:1];
            4'd2: q = win[11:2];
            4'd3: q = win[12:3];
            4'd4: q = win[13:4];
            4'd5: q = win[14:5];
            4'd6: q = win[15:6];
            4'd7: q = win[16:7];
            4'd8: q = win[17:8];
            4'd9: q = win[18:9];
            default: q = win[19:10];
        endcase
    end

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (q)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
    end

    always_comb begin
        qb   = q[9] ? ~q[7:0] : q[7:0];
        d    = '0;
        d[0] = qb[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (qb[i] ^ qb[i-1]) : ~(qb[i] ^ qb[i-1]);
        end
    end

    assign count_inc = count + 1'b1;

    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        count_nxt  = count;
        timer_nxt  = timer;
        case (state)
            SEARCH: begin
                if (is_tok) begin
                    state_nxt = VERIFY;
                    count_nxt = CW'(1);
                    timer_nxt = '0;
                end else if (timer == TIMER_LAST) begin
                    timer_nxt  = '0;
                    offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            VERIFY: begin
                if (is_tok) begin
                    count_nxt = count_inc;
                    if (count_inc == COUNT_LAST) begin
                        state_nxt = LOCKED;
                        timer_nxt = '0;
                    end
                end else begin
                    // an aliased token at the wrong offset fails here; retry same offset
                    state_nxt = SEARCH;
                    count_nxt = '0;
                    timer_nxt = '0;
                end
            end
            LOCKED: begin
                if (is_tok) begin
                    timer_nxt = '0;
                end else if (timer == TIMER_LAST) begin
                    state_nxt = SEARCH;
                    timer_nxt = '0;
                    count_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = SEARCH;
                count_nxt = '0;
                timer_nxt = '0;
            end
        endcase
    end

    // outputs follow the next state so they clear on the same edge lock drops
    always_comb begin
        ve_nxt      = 1'b0;
        data_nxt    = '0;
        control_nxt = '0;
        if (state_nxt == LOCKED) begin
            if (is_tok) begin
                control_nxt = tok_val;
            end else begin
                ve_nxt      = 1'b1;
                data_nxt    = d;
                control_nxt = control_out;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= SEARCH;
            prev        <= '0;
            offset      <= '0;
            count       <= '0;
            timer       <= '0;
            ve_out      <= 1'b0;
            data_out    <= '0;
            control_out <= '0;
        end else begin
            state       <= state_nxt;
            prev        <= tmds_in;
            offset      <= offset_nxt;
            count       <= count_nxt;
            timer       <= timer_nxt;
            ve_out      <= ve_nxt;
            data_out    <= data_nxt;
            control_out <= control_nxt;
        end
    end

    assign locked_out      = (state == LOCKED);
    assign slip_offset_out = offset;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: vector table at offset 0 plus multi-cycle sequences
// (miss timeout, broken verify, async reset, 3-bit rotated encoder stream).
module tb_tmds_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] tmds;
    logic       locked_out;
    logic [3:0] slip_offset_out;
    logic       ve_out;
    logic [7:0] data_out;
    logic [1:0] control_out;

    tmds_decoder #(.LOCK_COUNT(16), .MISS_LIMIT(2048)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .tmds_in(tmds),
        .locked_out(locked_out),
        .slip_offset_out(slip_offset_out),
        .ve_out(ve_out),
        .data_out(data_out),
        .control_out(control_out)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam logic [9:0] D0  = 10'b0100000000;  // decodes to 8'h00
    localparam logic [9:0] D1  = 10'b1011111111;  // decodes to 8'hFE
    localparam logic [9:0] DEF = 10'b0000001111;  // decodes to 8'hEF

    localparam int LINE  = 1650;
    localparam int ACT   = 1370;
    localparam int NSYM  = 6801;

    typedef struct {
        logic [9:0] word;
        logic       locked;
        logic       ve;
        logic [7:0] data;
        logic [1:0] ctrl;
    } vec_t;

    vec_t tbl[23];

    int n_chk  = 0;
    int n_fail = 0;
    int enc_cnt;

    logic [9:0] sym[NSYM];
    logic [7:0] pix[NSYM];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic l, input logic v,
                             input logic [7:0] dat, input logic [1:0] c);
        check({tag, "_locked"}, 32'(locked_out), 32'(l));
        check({tag, "_ve"},     32'(ve_out),     32'(v));
        check({tag, "_data"},   32'(data_out),   32'(dat));
        check({tag, "_ctrl"},   32'(control_out), 32'(c));
    endtask

    // outputs seen after each edge reflect the word sent one call earlier
    task automatic send(input logic [9:0] w);
        tmds = w;
        @(posedge clk);
        #1;
    endtask

    task automatic encode(input logic [7:0] dd, output logic [9:0] qq);
        logic [8:0] qm;
        int n1d, n1, n0;
        n1d   = $countones(dd);
        qm    = '0;
        qm[0] = dd[0];
        if (n1d > 4 || (n1d == 4 && dd[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ dd[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ dd[i];
            qm[8] = 1'b1;
        end
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (enc_cnt == 0 || n1 == n0) begin
            qq = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            enc_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((enc_cnt > 0 && n1 > n0) || (enc_cnt < 0 && n0 > n1)) begin
            qq = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt += (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            qq = {1'b0, qm[8], qm[7:0]};
            enc_cnt += n1 - n0 - (qm[8] ? 0 : 2);
        end
    endtask

    initial begin
        logic [9:0] ps, w;
        for (int i = 0; i < 16; i++) tbl[i] = '{T00, 1'b0, 1'b0, 8'h00, 2'b00};
        tbl[16] = '{D0,  1'b1, 1'b0, 8'h00, 2'b00};
        tbl[17] = '{D1,  1'b1, 1'b1, 8'h00, 2'b00};
        tbl[18] = '{T11, 1'b1, 1'b1, 8'hFE, 2'b00};
        tbl[19] = '{D0,  1'b1, 1'b0, 8'h00, 2'b11};
        tbl[20] = '{DEF, 1'b1, 1'b1, 8'h00, 2'b11};
        tbl[21] = '{D0,  1'b1, 1'b1, 8'hEF, 2'b11};
        tbl[22] = '{D0,  1'b1, 1'b1, 8'h00, 2'b11};

        // pixel 0 only in the first four lines keeps offsets 0..2 free of aliased tokens
        enc_cnt = 0;
        for (int s = 0; s < NSYM; s++) begin
            if ((s % LINE) < ACT) begin
                pix[s] = (s < 4 * LINE) ? 8'h00 : 8'((s * 7) + 3);
                encode(pix[s], sym[s]);
            end else begin
                pix[s]  = 8'h00;
                sym[s]  = T00;
                enc_cnt = 0;
            end
        end

        rst  = 1'b1;
        tmds = '0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 1'b0, 8'h00, 2'b00);
        check("reset_offset", 32'(slip_offset_out), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            send(tbl[i].word);
            check_out($sformatf("vec%0d", i), tbl[i].locked, tbl[i].ve, tbl[i].data, tbl[i].ctrl);
            check($sformatf("vec%0d_offset", i), 32'(slip_offset_out), 32'd0);
        end

        // miss timeout while locked
        send(T00);
        send(D0);
        check_out("tok_resync", 1'b1, 1'b0, 8'h00, 2'b00);
        for (int i = 1; i <= 2048; i++) begin
            send(D0);
            if (i == 2047) check_out("miss_2047", 1'b1, 1'b1, 8'h00, 2'b00);
            if (i == 2048) begin
                check_out("miss_2048", 1'b0, 1'b0, 8'h00, 2'b00);
                check("miss_offset", 32'(slip_offset_out), 32'd0);
            end
        end

        // verify interrupted by a data word
        for (int i = 0; i < 5; i++) send(T00);
        send(D0);
        check("brk_pre_locked", 32'(locked_out), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            send(T00);
            check($sformatf("brk_tok%0d_locked", k), 32'(locked_out), 32'd0);
        end
        send(D0);
        check("brk_lock", 32'(locked_out), 32'd1);
        check("brk_offset", 32'(slip_offset_out), 32'd0);

        // async reset mid-data
        send(D1);
        send(D1);
        check_out("pre_rst", 1'b1, 1'b1, 8'hFE, 2'b00);
        #3;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 1'b0, 8'h00, 2'b00);
        tmds = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            send(T00);
            check($sformatf("relock%0d_locked", k), 32'(locked_out), 32'd0);
        end
        send(D0);
        check("relock", 32'(locked_out), 32'd1);

        // 3-bit rotated encoder stream: symbol s starts at serial bit 10*s+3
        rst = 1'b1;
        tmds = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < NSYM; j++) begin
            ps = (j == 0) ? D0 : sym[j-1];
            w  = {sym[j][6:0], ps[9:7]};
            send(w);
            if (j == 2046) check("rot_off_a", 32'(slip_offset_out), 32'd0);
            if (j == 2047) check("rot_off_b", 32'(slip_offset_out), 32'd1);
            if (j == 4094) check("rot_off_c", 32'(slip_offset_out), 32'd1);
            if (j == 4095) check("rot_off_d", 32'(slip_offset_out), 32'd2);
            if (j == 6142) check("rot_off_e", 32'(slip_offset_out), 32'd2);
            if (j == 6143) check("rot_off_f", 32'(slip_offset_out), 32'd3);
            if (j == 6335) check("rot_prelock", 32'(locked_out), 32'd0);
            if (j == 6336) begin
                check_out("rot_lock", 1'b1, 1'b0, 8'h00, 2'b00);
                check("rot_lock_offset", 32'(slip_offset_out), 32'd3);
            end
            if (j == 6500) check_out("rot_blank", 1'b1, 1'b0, 8'h00, 2'b00);
            if (j >= 6601)
                check($sformatf("rot_pix%0d", j - 1), 32'({locked_out, ve_out, data_out}),
                      32'({1'b1, 1'b1, pix[j-1]}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
